signed_decimal_seg_display: RTL

//  Shows an NBITS-wide integer in decimal on the single 7-segment display, one digit at a time.

---
 rtl/seg_display_pkg.sv | 50 +++++
 rtl/bin2bcd_seq.sv | 68 ++++++
 rtl/signed_decimal_seg_display.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// seg_display_pkg
//   Shared types and constants for the signed decimal 7-segment display.
//   - state_t     : sequencer states (IDLE, CONVERT, SHOW, BLANK)
//   - SEG_GLYPH   : 7-segment patterns {g..a} for decimal digits 0-9
//   - SEG_MINUS   : pattern used for a leading '-' digit
//   - glyph()     : digit -> segment pattern, blank for non-decimal codes
//   - sig_digits(): number of significant digits in a packed BCD vector
package seg_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2,
        BLANK   = 2'd3
    } state_t;

    // Widest BCD vector sig_digits() can scan.
    localparam int MAX_DIGITS = 16;
    localparam int MAX_BCD_W  = 4 * MAX_DIGITS;

    localparam logic [7:0] SEG_MINUS = 8'h40;

    // Entry [d] is the pattern for digit d.
    localparam logic [9:0][6:0] SEG_GLYPH = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        g = 7'h00;
        for (int i = 0; i < 10; i++) begin
            if (d == 4'(i)) g = SEG_GLYPH[i];
        end
        return g;
    endfunction

    // Index of the highest non-zero digit plus one; an all-zero value
    // still counts as one digit so that '0' is displayed.
    function automatic int sig_digits(input logic [MAX_BCD_W-1:0] bcd,
                                      input int ndig);
        int n;
        n = 1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < ndig && bcd[4*i +: 4] != 4'd0) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble).
//   The first shift happens on the start edge itself, so the result is
//   ready NBITS-1 edges later and done pulses for exactly one cycle.
//   Ports:
//     clk_2  in   clock, rising edge
//     reset  in   synchronous active-high; clears the BCD register
//     start  in   begin converting i_bin (ignored while converting)
//     i_bin  in   NBITS unsigned value
//     o_done out  one-cycle pulse, o_bcd valid from then until next start
//     o_bcd  out  NDIGITS packed BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq
    import seg_display_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NDIGITS = 3
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NBITS-1:0]     i_bin,
    output logic                 o_done,
    output logic [4*NDIGITS-1:0] o_bcd
);

    localparam int BW = 4 * NDIGITS;
    localparam int CW = $clog2(NBITS);

    logic [NBITS-1:0] r_sh;
    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [BW-1:0]    w_adj;

    // Add 3 to every digit >= 5 before the shift so it carries correctly.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NDIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && r_cnt == '0) begin
                // BCD starts at zero, so the first shift needs no adjust.
                r_bcd <= BW'(i_bin[NBITS-1]);
                r_sh  <= {i_bin[NBITS-2:0], 1'b0};
                r_cnt <= CW'(NBITS - 1);
            end else if (r_cnt != '0) begin
                r_bcd <= {w_adj[BW-2:0], r_sh[NBITS-1]};
                r_sh  <= {r_sh[NBITS-2:0], 1'b0};
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) r_done <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/signed_decimal_seg_display.sv
// signed_decimal_seg_display
//   Shows an NBITS integer in decimal on one 7-segment display, one digit
//   at a time, most significant first, followed by a blank, repeating
//   until a new load. Negative values (signed_mode) light dp on every
//   digit.
//   Build option SEG_MINUS_GLYPH_EN: dp stays dark and a negative value is
//   instead preceded by a '-' digit (seg=8'h40, digit_idx=NDIGITS-1).
//   Ports:
//     clk_2       in   clock, rising edge
//     reset       in   synchronous active-high
//     value       in   NBITS value, sampled on an accepted load
//     signed_mode in   1: value is two's complement
//     load        in   start strobe; ignored while busy
//     seg         out  {dp,g,f,e,d,c,b,a}, active high
//     digit_idx   out  position of the shown digit (0 = least significant)
//     busy        out  conversion in progress
//     digit_valid out  seg currently shows a digit
module signed_decimal_seg_display
    import seg_display_pkg::*;
#(
    parameter int NBITS       = 8,
    parameter int NDIGITS     = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic [NBITS-1:0]           value,
    input  logic                       signed_mode,
    input  logic                       load,
    output logic [7:0]                 seg,
    output logic [$clog2(NDIGITS)-1:0] digit_idx,
    output logic                       busy,
    output logic                       digit_valid
);

    localparam int BW = 4 * NDIGITS;
    localparam int IW = $clog2(NDIGITS);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

`ifdef SEG_MINUS_GLYPH_EN
    localparam bit MINUS_EN = 1'b1;
`else
    localparam bit MINUS_EN = 1'b0;
`endif

    state_t         r_state, w_state_nx;
    logic [IW-1:0]  r_idx,   w_idx_nx;
    logic [HW-1:0]  r_hold,  w_hold_nx;
    logic           r_minus, w_minus_nx;   // showing the '-' digit
    logic           r_neg,   w_neg_nx;

    logic             w_neg;
    logic [NBITS-1:0] w_mag;
    logic             w_start;
    logic             w_done;
    logic [BW-1:0]    w_bcd;
    logic [IW-1:0]    w_top;
    logic [3:0]       w_digit;

    // Magnitude in NBITS unsigned bits: -2**(NBITS-1) maps onto itself.
    assign w_neg = signed_mode & value[NBITS-1];
    assign w_mag = w_neg ? (~value + 1'b1) : value;

    bin2bcd_seq #(
        .NBITS   (NBITS),
        .NDIGITS (NDIGITS)
    ) u_bin2bcd (
        .clk_2  (clk_2),
        .reset  (reset),
        .start  (w_start),
        .i_bin  (w_mag),
        .o_done (w_done),
        .o_bcd  (w_bcd)
    );

    assign w_top   = IW'(sig_digits(MAX_BCD_W'(w_bcd), NDIGITS) - 1);
    assign w_digit = w_bcd[4*r_idx +: 4];

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_minus <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_hold  <= w_hold_nx;
            r_minus <= w_minus_nx;
            r_neg   <= w_neg_nx;
        end
    end

    // r_hold counts HOLD_CYCLES..1; the step away happens when it reads 1.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_hold_nx  = r_hold;
        w_minus_nx = r_minus;
        w_neg_nx   = r_neg;
        w_start    = 1'b0;

        case (r_state)
            IDLE: ;
            CONVERT: begin
                if (w_done) begin
                    w_state_nx = SHOW;
                    w_idx_nx   = w_top;
                    w_hold_nx  = HW'(HOLD_CYCLES);
                    w_minus_nx = MINUS_EN & r_neg;
                end
            end
            SHOW: begin
                if (r_hold == HW'(1)) begin
                    w_hold_nx = HW'(HOLD_CYCLES);
                    if (r_minus) begin
                        w_minus_nx = 1'b0;
                        w_idx_nx   = w_top;
                    end else if (r_idx == '0) begin
                        w_state_nx = BLANK;
                    end else begin
                        w_idx_nx = r_idx - 1'b1;
                    end
                end else begin
                    w_hold_nx = r_hold - 1'b1;
                end
            end
            BLANK: begin
                if (r_hold == HW'(1)) begin
                    w_state_nx = SHOW;
                    w_idx_nx   = w_top;
                    w_hold_nx  = HW'(HOLD_CYCLES);
                    w_minus_nx = MINUS_EN & r_neg;
                end else begin
                    w_hold_nx = r_hold - 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase

        // A load outside CONVERT abandons whatever is on display.
        if (load && r_state != CONVERT) begin
            w_state_nx = CONVERT;
            w_start    = 1'b1;
            w_neg_nx   = w_neg;
            w_minus_nx = 1'b0;
            w_idx_nx   = '0;
            w_hold_nx  = '0;
        end
    end

    always_comb begin
        seg         = 8'h00;
        digit_idx   = '0;
        digit_valid = 1'b0;
        if (r_state == SHOW) begin
            digit_valid = 1'b1;
            if (r_minus) begin
                seg       = SEG_MINUS;
                digit_idx = IW'(NDIGITS - 1);
            end else begin
                seg       = {r_neg & ~MINUS_EN, glyph(w_digit)};
                digit_idx = r_idx;
            end
        end
    end

    assign busy = (r_state == CONVERT);

endmodule
